// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its
// pipeline registers.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int              PC_W       = 16;
  localparam logic [3:0]      HLT_OP_DEF = 4'hF;
  localparam logic [PC_W-1:0] PC_INC     = 16'd2;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline stage register with load/hold/flush and sync reset.
// Flush wins over load; flush clears only the valid bit.
module ifid_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register, runs the imem handshake
// and owns the IF/ID register, handling stalls, redirects and HLT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [3:0] HLT_OP = HLT_OP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  output logic [15:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] redir_tgt_q, redir_tgt_d;
  logic [PC_W-1:0] pc_plus2;
  logic            fetch_done;
  logic            is_hlt;
  logic            ifid_load;
  logic            ifid_flush;

  // PC is only ever advanced on fetch_done, so pc_in doubles as the held address.
  assign pc_plus2   = pc_in + PC_INC;
  assign imem_req   = !rst && (state_q != HALTED);
  assign imem_addr  = pc_in;
  assign fetch_done = imem_req && imem_ready;
  assign is_hlt     = (imem_data[15:12] == HLT_OP);
  assign halted     = (state_q == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      redir_tgt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_tgt_q <= redir_tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    redir_tgt_d = redir_tgt_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          if (!fetch_done) begin
            state_d     = DRAIN;
            redir_tgt_d = redirect_target;
          end
        end else if (!stall_id && fetch_done && is_hlt) begin
          state_d = HALTED;
        end
      end
      DRAIN: begin
        if (redirect) redir_tgt_d = redirect_target;
        if (fetch_done) state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // A redirect arriving on the same cycle DRAIN completes is the newer target.
  always_comb begin
    pc_en      = 1'b0;
    pc_next    = pc_plus2;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (fetch_done) begin
            pc_en   = 1'b1;
            pc_next = redirect_target;
          end
        end else if (stall_id) begin
          ifid_flush = 1'b0;
        end else if (fetch_done) begin
          ifid_load = 1'b1;
          pc_en     = !is_hlt;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        if (fetch_done) begin
          pc_en   = 1'b1;
          pc_next = redirect ? redirect_target : redir_tgt_q;
        end
      end
      HALTED:  ifid_flush = !stall_id;
      default: ifid_flush = 1'b1;
    endcase
  end

  ifid_reg #(
    .DATA_W(2*PC_W)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .data_in  ({imem_data, pc_plus2}),
    .data_out ({ifid_instr, ifid_pc_plus2}),
    .valid_out(ifid_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_ready = 1'b0;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(.HLT_OP(4'hF)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_next        (pc_next),
    .pc_en          (pc_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_ready     (imem_ready),
    .stall_id       (stall_id),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .ifid_valid     (ifid_valid),
    .halted         (halted)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: PC register, IF/ID contents, halt flag, pending redirect.
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_instr = 16'h0000, m_pc2 = 16'h0000;
  logic        m_valid = 1'b0, m_halted = 1'b0, m_pend = 1'b0;
  logic [15:0] m_tgt = 16'h0000;
  logic [15:0] n_pc, n_instr, n_pc2, n_tgt;
  logic        n_valid, n_halted, n_pend;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compute the model's view and compare everything.
  task automatic setup(input logic r, input logic rdy, input logic [15:0] data,
                       input logic st, input logic rd, input logic [15:0] tgt);
    logic        e_req, e_en, done;
    logic [15:0] e_next, inc, t;
    @(negedge clk);
    rst = r; imem_ready = rdy; imem_data = data; stall_id = st;
    redirect = rd; redirect_target = tgt; pc_in = m_pc;
    #2;
    inc    = m_pc + 16'd2;
    e_req  = !r && !m_halted;
    done   = e_req && rdy;
    e_en   = 1'b0;
    e_next = inc;
    n_instr = m_instr; n_pc2 = m_pc2; n_valid = m_valid;
    n_halted = m_halted; n_pend = m_pend; n_tgt = m_tgt;
    if (r) begin
      n_instr = 16'h0000; n_pc2 = 16'h0000; n_valid = 1'b0;
      n_halted = 1'b0; n_pend = 1'b0; n_tgt = 16'h0000;
    end else if (m_halted) begin
      if (!st) n_valid = 1'b0;
    end else if (m_pend) begin
      n_valid = 1'b0;
      t = rd ? tgt : m_tgt;
      n_tgt = t;
      if (done) begin e_en = 1'b1; e_next = t; n_pend = 1'b0; end
    end else if (rd) begin
      n_valid = 1'b0;
      if (done) begin e_en = 1'b1; e_next = tgt; end
      else begin n_pend = 1'b1; n_tgt = tgt; end
    end else if (st) begin
      n_valid = m_valid;
    end else if (done) begin
      n_instr = data; n_pc2 = inc; n_valid = 1'b1;
      if (data[15:12] == 4'hF) n_halted = 1'b1;
      else begin e_en = 1'b1; e_next = inc; end
    end else begin
      n_valid = 1'b0;
    end
    n_pc = r ? 16'h0000 : (e_en ? e_next : m_pc);

    chk("imem_req", {15'd0, imem_req}, {15'd0, e_req});
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc_en", {15'd0, pc_en}, {15'd0, e_en});
    chk("pc_next", pc_next, e_next);
    chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    if (m_valid) begin
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc_plus2", ifid_pc_plus2, m_pc2);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_pc = n_pc; m_instr = n_instr; m_pc2 = n_pc2; m_valid = n_valid;
    m_halted = n_halted; m_pend = n_pend; m_tgt = n_tgt;
  endtask

  initial begin
    // Reset held two cycles with memory ready
    setup(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_pc_en", {15'd0, pc_en}, 16'd0);
    advance();
    setup(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("rst_req2", {15'd0, imem_req}, 16'd0);
    chk("rst_pc_en2", {15'd0, pc_en}, 16'd0);
    chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    advance();

    // Straight-line fetch
    setup(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    chk("lit_req", {15'd0, imem_req}, 16'd1);
    chk("lit_addr0", imem_addr, 16'h0000);
    chk("lit_next2", pc_next, 16'h0002);
    chk("lit_en1", {15'd0, pc_en}, 16'd1);
    advance();

    // Stall two cycles
    setup(1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 16'h0000);
    chk("lit_instr", ifid_instr, 16'h1234);
    chk("lit_pc2", ifid_pc_plus2, 16'h0002);
    chk("lit_valid", {15'd0, ifid_valid}, 16'd1);
    chk("lit_stall_en", {15'd0, pc_en}, 16'd0);
    chk("lit_stall_addr", imem_addr, 16'h0002);
    advance();
    setup(1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 16'h0000);
    chk("lit_stall_hold", ifid_instr, 16'h1234);
    chk("lit_stall_addr2", imem_addr, 16'h0002);
    advance();
    setup(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0, 16'h0000);
    chk("lit_unstall_en", {15'd0, pc_en}, 16'd1);
    advance();

    // Redirect during a 3-cycle miss
    m_pc = 16'h0010;
    setup(1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1, 16'h0040);
    chk("lit_after_stall", ifid_instr, 16'h5678);
    chk("lit_after_stall_pc2", ifid_pc_plus2, 16'h0004);
    chk("lit_miss_addr1", imem_addr, 16'h0010);
    advance();
    for (int i = 0; i < 2; i++) begin
      setup(1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
      chk("lit_miss_addr", imem_addr, 16'h0010);
      chk("lit_miss_valid", {15'd0, ifid_valid}, 16'd0);
      advance();
    end
    setup(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
    chk("lit_redir_next", pc_next, 16'h0040);
    chk("lit_redir_en", {15'd0, pc_en}, 16'd1);
    chk("lit_redir_valid", {15'd0, ifid_valid}, 16'd0);
    advance();

    // HLT
    m_pc = 16'h0020;
    setup(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000);
    chk("lit_hlt_en", {15'd0, pc_en}, 16'd0);
    advance();
    setup(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 16'h0080);
    chk("lit_hlt_instr", ifid_instr, 16'hF000);
    chk("lit_hlt_halted", {15'd0, halted}, 16'd1);
    chk("lit_hlt_req", {15'd0, imem_req}, 16'd0);
    chk("lit_hlt_en2", {15'd0, pc_en}, 16'd0);
    advance();
    setup(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
    chk("lit_hlt_stay", {15'd0, halted}, 16'd1);
    chk("lit_hlt_bubble", {15'd0, ifid_valid}, 16'd0);
    advance();
    setup(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    advance();
    setup(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("lit_unhalt", {15'd0, halted}, 16'd0);
    chk("lit_unhalt_req", {15'd0, imem_req}, 16'd1);
    advance();

    // Wrap-around
    m_pc = 16'hFFFE;
    setup(1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 16'h0000);
    chk("lit_wrap_next", pc_next, 16'h0000);
    advance();
    setup(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("lit_wrap_pc2", ifid_pc_plus2, 16'h0000);
    chk("lit_wrap_valid", {15'd0, ifid_valid}, 16'd1);
    advance();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, rdy, st, rd;
      logic [15:0] data, tgt;
      r    = m_halted ? ($urandom_range(9, 0) == 0) : ($urandom_range(199, 0) == 0);
      rdy  = ($urandom_range(9, 0) < 7);
      st   = ($urandom_range(9, 0) < 2);
      rd   = ($urandom_range(9, 0) == 0);
      data = 16'($urandom);
      if (data[15:12] == 4'hF && $urandom_range(3, 0) != 0) data[15] = 1'b0;
      tgt  = {16'($urandom) & 16'hFFFE};
      setup(r, rdy, data, st, rd, tgt);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the PC register and the decode stage. It drives the PC register's `next`/`en` inputs and runs the instruction-memory request handshake. It also owns the IF/ID pipeline register (instruction, PC+2, valid), and handles decode-stage stalls, branch redirects and the HLT instruction.

## Interface
Parameters:
- `HLT_OP`, default 4'hF: opcode (`instr[15:12]`) that halts fetch.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `pc_in`  in  16: current PC from the PC register.
- `pc_next`  out  16: next-PC value to the PC register.
- `pc_en`  out  1: PC register write enable.
- `imem_req`  out  1: instruction-memory request.
- `imem_addr`  out  16: request address.
- `imem_data`  in  16: fetched instruction, valid when `imem_req & imem_ready`.
- `imem_ready`  in  1: memory completes the request this cycle.
- `stall_id`  in  1: decode hazard. Hold IF/ID and PC.
- `redirect`  in  1: taken branch resolved in ID.
- `redirect_target`  in  16: branch target.
- `ifid_instr`  out  16: IF/ID instruction.
- `ifid_pc_plus2`  out  16: IF/ID PC+2.
- `ifid_valid`  out  1: IF/ID holds a live instruction.
- `halted`  out  1: fetch stopped on HLT.

## Operation
- States: RUN, DRAIN, HALTED. Reset state is RUN.
- Reset values:
  - `ifid_valid` = 0, `ifid_instr` = 0x0000, `ifid_pc_plus2` = 0x0000.
  - `halted` = 0, internal `redir_tgt` = 0x0000.
  - While `rst` is high: `imem_req` = 0 and `pc_en` = 0.
- `fetch_done` = `imem_req & imem_ready`.
- `imem_req` is 1 in RUN and DRAIN, and 0 in HALTED or during reset.
- Handshake rule: once `imem_req` is asserted, `imem_addr` stays stable until `fetch_done`.
- RUN: `imem_addr` = `pc_in`. Rules in priority order:
  1. `redirect`:
     - IF/ID `valid` <= 0.
     - If `fetch_done`: data is discarded, `pc_next` = `redirect_target`, `pc_en` = 1, stay in RUN.
     - Otherwise: `redir_tgt` <= `redirect_target`, `pc_en` = 0, go to DRAIN.
  2. `stall_id`:
     - IF/ID holds, `pc_en` = 0.
     - Any completed fetch is dropped. The same address is refetched later, which is harmless because imem is read-only.
  3. `fetch_done`:
     - IF/ID <= {`imem_data`, `pc_in`+2, 1}.
     - If opcode == `HLT_OP`: `pc_en` = 0 (PC keeps the HLT address) and go to HALTED.
     - Otherwise: `pc_next` = `pc_in`+2, `pc_en` = 1.
  4. Otherwise (memory waiting): IF/ID `valid` <= 0 (bubble), `pc_en` = 0.
- DRAIN:
  - `imem_addr` keeps the old `pc_in`, and `ifid_valid` <= 0 each cycle.
  - On `fetch_done`: data is discarded, `pc_next` = `redir_tgt`, `pc_en` = 1, go to RUN.
  - A further `redirect` in DRAIN overwrites `redir_tgt`.
  - `stall_id` is ignored in DRAIN.
- HALTED:
  - `halted` = 1, `pc_en` = 0.
  - IF/ID holds the HLT while `stall_id` = 1; otherwise `ifid_valid` <= 0 on the next edge.
  - `redirect` is ignored. Only `rst` exits HALTED.
- When `pc_en` = 0, `pc_next` = `pc_in`+2 (a don't-care value).
- Arithmetic: all PC math is 16-bit modulo 2^16, so 0xFFFE+2 = 0x0000.
- `rst` mid-fetch: the outstanding request is abandoned, the state goes to RUN, and IF/ID is cleared.

## Timing
- `pc_next`, `pc_en`, `imem_req` and `imem_addr` are combinational from the state and inputs. The PC register samples them at the same rising edge.
- Fetch latency: imem data captured at edge N appears on `ifid_*` after edge N.
- With `imem_ready` held at 1, throughput is 1 instruction per cycle.
- A memory wait of k cycles inserts k bubbles.
- A redirect costs one bubble (the flushed slot). A redirect during a wait additionally costs the remaining wait cycles.
- `halted` rises at the same edge that loads the HLT into IF/ID.

## Structure
- Shared package `fetch_pkg`:
  - state enum (RUN, DRAIN, HALTED);
  - `HLT_OP` default;
  - `PC_W` = 16;
  - `PC_INC` = 2.
- Sub-module `ifid_reg`: pipeline register with load, hold and flush controls and synchronous reset. It is reused for later stage registers.

## Test plan
- Reset: hold `rst` high 2 cycles with `imem_ready` = 1.
  - During reset: `imem_req` = 0, `pc_en` = 0, `ifid_valid` = 0, `halted` = 0.
  - First cycle after release: `imem_req` = 1, `imem_addr` = 0x0000.
- Straight-line fetch: `pc_in` = 0x0000, `imem_data` = 0x1234, `imem_ready` = 1.
  - Same cycle: `pc_next` = 0x0002, `pc_en` = 1.
  - Next cycle: `ifid_instr` = 0x1234, `ifid_pc_plus2` = 0x0002, `ifid_valid` = 1.
- Redirect during a miss: `pc_in` = 0x0010, `imem_ready` = 0 for 3 cycles, `redirect` = 1 with target 0x0040 in cycle 1.
  - `imem_addr` stays 0x0010 until `imem_ready`, and that data is discarded.
  - On the ready cycle: `pc_next` = 0x0040, `pc_en` = 1.
  - `ifid_valid` = 0 throughout.
- Stall: `stall_id` = 1 for 2 cycles with `imem_ready` = 1.
  - IF/ID holds its previous values, `pc_en` = 0, and the same `imem_addr` is re-requested.
  - After the stall releases, the held address is fetched normally.
- HLT: `imem_data` = 0xF000 at `pc_in` = 0x0020.
  - Next cycle: `ifid_instr` = 0xF000, `halted` = 1, `imem_req` = 0, `pc_en` = 0.
  - A later `redirect` has no effect; `rst` returns to RUN with `halted` = 0.
- Wrap-around: `pc_in` = 0xFFFE fetched → `pc_next` = 0x0000 and `ifid_pc_plus2` = 0x0000.
